// File: rtl/pong_pkg.sv
// Shared definitions for the two-player ball controller: FSM encoding and
// geometry helpers used to derive centre and paddle-face constants.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    function automatic int f_score_w(input int win_score);
        return $clog2(win_score + 1);
    endfunction

    function automatic int f_centre(input int active, input int size);
        return (active - size) / 2;
    endfunction

    // Column the ball's left edge rests on when it touches the P1 paddle front.
    function automatic int f_p1_face(input int gap, input int pad_w);
        return gap + pad_w;
    endfunction

    // Column the ball's left edge rests on when its right edge touches P2.
    function automatic int f_p2_face(input int active, input int gap, input int pad_w,
                                     input int size);
        return active - gap - pad_w - size;
    endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// Counts tick strobes from 0 to N-1; o_Done is high on the tick that reaches
// N-1, after which the count wraps to 0. i_Clear restarts the count.
module frame_delay_counter #(
    parameter int N = 60
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Tick,
    output logic o_Done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    assign o_Done = i_Tick && !i_Clear && (r_count == C_LAST);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_count <= '0;
        end else if (i_Clear) begin
            r_count <= '0;
        end else if (i_Tick) begin
            if (r_count == C_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_ball_2p_ctrl.sv
// Two-player pong ball controller: ball motion, wall/paddle bounces, misses,
// scores, and the IDLE/PLAY/POINT/GAME_OVER flow, plus the ball pixel strobe.
module pong_ball_2p_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_GAP   = 16,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic [$clog2(H_TOTAL)-1:0]          i_H_count,
    input  logic [$clog2(V_TOTAL)-1:0]          i_V_count,
    input  logic                                i_Frame_end,
    input  logic                                i_Start,
    input  logic [$clog2(V_ACTIVE)-1:0]         i_P1_Paddle_Y,
    input  logic [$clog2(V_ACTIVE)-1:0]         i_P2_Paddle_Y,
    output logic                                o_Draw_Ball,
    output logic [$clog2(H_ACTIVE)-1:0]         o_Ball_X,
    output logic [$clog2(V_ACTIVE)-1:0]         o_Ball_Y,
    output logic [f_score_w(WIN_SCORE)-1:0]     o_P1_Score,
    output logic [f_score_w(WIN_SCORE)-1:0]     o_P2_Score,
    output logic [1:0]                          o_State,
    output logic                                o_Point
);

    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int SAW     = XW + 1;
    localparam int EW      = ((HCW > VCW) ? HCW : VCW) + 2;
    localparam int SCORE_W = f_score_w(WIN_SCORE);

    localparam logic signed [SAW-1:0] C_SPD     = SAW'(BALL_SPEED);
    localparam logic signed [SAW-1:0] C_ZERO    = '0;
    localparam logic signed [SAW-1:0] C_XMAX    = SAW'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [SAW-1:0] C_YMAX    = SAW'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [SAW-1:0] C_P1_FACE = SAW'(f_p1_face(PADDLE_GAP, PADDLE_W));
    localparam logic signed [SAW-1:0] C_P2_FACE =
        SAW'(f_p2_face(H_ACTIVE, PADDLE_GAP, PADDLE_W, BALL_SIZE));
    localparam logic signed [SAW-1:0] C_SIZE    = SAW'(BALL_SIZE);
    localparam logic signed [SAW-1:0] C_PH      = SAW'(PADDLE_H);

    localparam logic [XW-1:0]      C_CX    = XW'(f_centre(H_ACTIVE, BALL_SIZE));
    localparam logic [YW-1:0]      C_CY    = YW'(f_centre(V_ACTIVE, BALL_SIZE));
    localparam logic [HCW-1:0]     C_HACT  = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0]     C_VACT  = VCW'(V_ACTIVE);
    localparam logic [EW-1:0]      C_DSIZE = EW'(BALL_SIZE);
    localparam logic [SCORE_W-1:0] C_WIN   = SCORE_W'(WIN_SCORE);

    state_e               r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_dx;       // 1 = moving right
    logic                 r_dy;       // 1 = moving down
    logic [SCORE_W-1:0]   r_p1_score;
    logic [SCORE_W-1:0]   r_p2_score;
    logic                 r_point;
    logic                 r_draw;

    logic signed [SAW-1:0] w_x_s;
    logic signed [SAW-1:0] w_y_s;
    logic signed [SAW-1:0] w_nx;
    logic signed [SAW-1:0] w_ny;
    logic signed [SAW-1:0] w_nx_fin;
    logic signed [SAW-1:0] w_ny_fin;
    logic signed [SAW-1:0] w_p1_top;
    logic signed [SAW-1:0] w_p2_top;
    logic                  w_dx_nxt;
    logic                  w_dy_nxt;
    logic                  w_p1_hit;
    logic                  w_p2_hit;
    logic                  w_p1_scores;
    logic                  w_p2_scores;
    logic                  w_score_evt;
    logic                  w_serve_tick;
    logic                  w_serve_done;
    logic                  w_draw;
    logic [EW-1:0]         w_h_e;
    logic [EW-1:0]         w_v_e;
    logic [EW-1:0]         w_bx_e;
    logic [EW-1:0]         w_by_e;

    // Next-frame geometry. Walls are inclusive, so the ball reverses on the
    // same frame it lands on row 0 or the bottom row; paddle overlap uses the
    // post-bounce row so a corner hit applies both reflections.
    always_comb begin
        w_x_s       = $signed({1'b0, r_x});
        w_y_s       = $signed(SAW'(r_y));
        w_p1_top    = $signed(SAW'(i_P1_Paddle_Y));
        w_p2_top    = $signed(SAW'(i_P2_Paddle_Y));
        w_nx        = r_dx ? (w_x_s + C_SPD) : (w_x_s - C_SPD);
        w_ny        = r_dy ? (w_y_s + C_SPD) : (w_y_s - C_SPD);
        w_ny_fin    = w_ny;
        w_dy_nxt    = r_dy;
        w_nx_fin    = w_nx;
        w_dx_nxt    = r_dx;
        w_p1_scores = 1'b0;
        w_p2_scores = 1'b0;

        if (w_ny <= C_ZERO) begin
            w_ny_fin = C_ZERO;
            w_dy_nxt = 1'b1;
        end else if (w_ny >= C_YMAX) begin
            w_ny_fin = C_YMAX;
            w_dy_nxt = 1'b0;
        end

        w_p1_hit = !r_dx && (w_nx <= C_P1_FACE) && (w_x_s >= C_P1_FACE)
                   && ((w_ny_fin + C_SIZE) > w_p1_top) && (w_ny_fin < (w_p1_top + C_PH));
        w_p2_hit = r_dx && (w_nx >= C_P2_FACE) && (w_x_s <= C_P2_FACE)
                   && ((w_ny_fin + C_SIZE) > w_p2_top) && (w_ny_fin < (w_p2_top + C_PH));

        if (w_p1_hit) begin
            w_nx_fin = C_P1_FACE;
            w_dx_nxt = 1'b1;
        end else if (w_p2_hit) begin
            w_nx_fin = C_P2_FACE;
            w_dx_nxt = 1'b0;
        end else if (w_nx < C_ZERO) begin
            w_p2_scores = 1'b1;
        end else if (w_nx > C_XMAX) begin
            w_p1_scores = 1'b1;
        end
    end

    assign w_score_evt  = (r_state == ST_PLAY) && i_Frame_end && (w_p1_scores || w_p2_scores);
    assign w_serve_tick = (r_state == ST_POINT) && i_Frame_end;

    frame_delay_counter #(
        .N (SERVE_FRAMES)
    ) u_serve_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (w_score_evt),
        .i_Tick  (w_serve_tick),
        .o_Done  (w_serve_done)
    );

    assign w_h_e  = EW'(i_H_count);
    assign w_v_e  = EW'(i_V_count);
    assign w_bx_e = EW'(r_x);
    assign w_by_e = EW'(r_y);
    assign w_draw = (r_state != ST_GAME_OVER)
                    && (i_H_count < C_HACT) && (i_V_count < C_VACT)
                    && (w_h_e >= w_bx_e) && (w_h_e < (w_bx_e + C_DSIZE))
                    && (w_v_e >= w_by_e) && (w_v_e < (w_by_e + C_DSIZE));

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_x        <= C_CX;
            r_y        <= C_CY;
            r_dx       <= 1'b1;
            r_dy       <= 1'b1;
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_point    <= 1'b0;
            r_draw     <= 1'b0;
        end else begin
            r_point <= 1'b0;
            r_draw  <= w_draw;
            case (r_state)
                ST_IDLE: begin
                    // A start on a frame-end cycle takes priority; no motion.
                    if (i_Start) begin
                        r_state <= ST_PLAY;
                        r_x     <= C_CX;
                        r_y     <= C_CY;
                        r_dx    <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (i_Frame_end) begin
                        if (w_p1_scores || w_p2_scores) begin
                            r_point <= 1'b1;
                            r_state <= ST_POINT;
                            r_x     <= C_CX;
                            r_y     <= C_CY;
                            r_dx    <= w_p1_scores;
                            r_dy    <= w_dy_nxt;
                            if (w_p1_scores) begin
                                r_p1_score <= r_p1_score + 1'b1;
                            end else begin
                                r_p2_score <= r_p2_score + 1'b1;
                            end
                        end else begin
                            r_x  <= w_nx_fin[XW-1:0];
                            r_y  <= w_ny_fin[YW-1:0];
                            r_dx <= w_dx_nxt;
                            r_dy <= w_dy_nxt;
                        end
                    end
                end
                ST_POINT: begin
                    if (w_serve_done) begin
                        if ((r_p1_score == C_WIN) || (r_p2_score == C_WIN)) begin
                            r_state <= ST_GAME_OVER;
                        end else begin
                            r_state <= ST_PLAY;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Start) begin
                        r_state    <= ST_PLAY;
                        r_p1_score <= '0;
                        r_p2_score <= '0;
                        r_x        <= C_CX;
                        r_y        <= C_CY;
                        r_dx       <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_Draw_Ball = r_draw;
    assign o_Ball_X    = r_x;
    assign o_Ball_Y    = r_y;
    assign o_P1_Score  = r_p1_score;
    assign o_P2_Score  = r_p2_score;
    assign o_State     = r_state;
    assign o_Point     = r_point;

endmodule

// File: tb/tb_pong_ball_2p_ctrl.sv
// Bench for pong_ball_2p_ctrl: randomized paddles, probes and start pulses
// checked against a frame-level model of the game rules.
module tb_pong_ball_2p_ctrl;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int BALL_SIZE    = 8;
    localparam int BALL_SPEED   = 2;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_GAP   = 16;
    localparam int WIN_SCORE    = 9;
    localparam int SERVE_FRAMES = 60;

    localparam int CX      = (H_ACTIVE - BALL_SIZE) / 2;
    localparam int CY      = (V_ACTIVE - BALL_SIZE) / 2;
    localparam int X_MAX   = H_ACTIVE - BALL_SIZE;
    localparam int Y_MAX   = V_ACTIVE - BALL_SIZE;
    localparam int P1_FACE = PADDLE_GAP + PADDLE_W;
    localparam int P2_FACE = H_ACTIVE - PADDLE_GAP - PADDLE_W - BALL_SIZE;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int PYW     = $clog2(V_ACTIVE);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int SW      = $clog2(WIN_SCORE + 1);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           i_Reset;
    logic [HCW-1:0] i_H_count;
    logic [VCW-1:0] i_V_count;
    logic           i_Frame_end;
    logic           i_Start;
    logic [PYW-1:0] i_P1_Paddle_Y;
    logic [PYW-1:0] i_P2_Paddle_Y;
    logic           o_Draw_Ball;
    logic [XW-1:0]  o_Ball_X;
    logic [PYW-1:0] o_Ball_Y;
    logic [SW-1:0]  o_P1_Score;
    logic [SW-1:0]  o_P2_Score;
    logic [1:0]     o_State;
    logic           o_Point;

    pong_ball_2p_ctrl dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_H_count     (i_H_count),
        .i_V_count     (i_V_count),
        .i_Frame_end   (i_Frame_end),
        .i_Start       (i_Start),
        .i_P1_Paddle_Y (i_P1_Paddle_Y),
        .i_P2_Paddle_Y (i_P2_Paddle_Y),
        .o_Draw_Ball   (o_Draw_Ball),
        .o_Ball_X      (o_Ball_X),
        .o_Ball_Y      (o_Ball_Y),
        .o_P1_Score    (o_P1_Score),
        .o_P2_Score    (o_P2_Score),
        .o_State       (o_State),
        .o_Point       (o_Point)
    );

    // scoreboard
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: game state in plain integers, velocity as +1/-1
    int m_state, m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_serve_left;
    bit m_point;

    function automatic void model_reset();
        m_state = 0; m_x = CX; m_y = CY; m_vx = 1; m_vy = 1;
        m_s1 = 0; m_s2 = 0; m_serve_left = 0; m_point = 0;
    endfunction

    function automatic void model_award(input int scorer);
        if (scorer == 1) m_s1++; else m_s2++;
        m_point = 1;
        m_x = CX;
        m_y = CY;
        m_vx = (scorer == 1) ? 1 : -1;
        m_state = 2;
        m_serve_left = SERVE_FRAMES;
    endfunction

    function automatic void model_edge(input bit fe, input bit st, input int p1y, input int p2y);
        int nx, ny;
        bit hit1, hit2;
        m_point = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_x = CX; m_y = CY; m_vx = 1; end
            1: if (fe) begin
                nx = m_x + BALL_SPEED * m_vx;
                ny = m_y + BALL_SPEED * m_vy;
                if (ny <= 0) begin ny = 0; m_vy = 1; end
                else if (ny >= Y_MAX) begin ny = Y_MAX; m_vy = -1; end
                hit1 = (m_vx < 0) && (nx <= P1_FACE) && (m_x >= P1_FACE)
                       && (ny + BALL_SIZE > p1y) && (ny < p1y + PADDLE_H);
                hit2 = (m_vx > 0) && (nx >= P2_FACE) && (m_x <= P2_FACE)
                       && (ny + BALL_SIZE > p2y) && (ny < p2y + PADDLE_H);
                if (hit1) begin m_x = P1_FACE; m_y = ny; m_vx = 1; end
                else if (hit2) begin m_x = P2_FACE; m_y = ny; m_vx = -1; end
                else if (nx < 0) model_award(2);
                else if (nx > X_MAX) model_award(1);
                else begin m_x = nx; m_y = ny; end
            end
            2: if (fe) begin
                m_serve_left--;
                if (m_serve_left == 0)
                    m_state = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) ? 3 : 1;
            end
            3: if (st) begin m_s1 = 0; m_s2 = 0; m_x = CX; m_y = CY; m_vx = 1; m_state = 1; end
            default: ;
        endcase
    endfunction

    function automatic bit model_draw(input int h, input int v);
        return (m_state != 3) && (h < H_ACTIVE) && (v < V_ACTIVE)
               && (h >= m_x) && (h < m_x + BALL_SIZE) && (v >= m_y) && (v < m_y + BALL_SIZE);
    endfunction

    // stimulus helpers
    function automatic int near(input int c);
        int r;
        r = c - 3 + int'($urandom_range(0, BALL_SIZE + 5));
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int rand_h();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, H_TOTAL - 1));
        return near(m_x);
    endfunction

    function automatic int rand_v();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, V_TOTAL - 1));
        return near(m_y);
    endfunction

    function automatic int track(input int y);
        int p;
        p = y - int'($urandom_range(2, PADDLE_H - 10));
        if (p < 0) p = 0;
        if (p > V_ACTIVE - PADDLE_H) p = V_ACTIVE - PADDLE_H;
        return p;
    endfunction

    function automatic int avoid(input int y);
        return (y < V_ACTIVE / 2) ? 400 : 0;
    endfunction

    task automatic check_outputs();
        chk("state", 32'(o_State), 32'(m_state));
        chk("ball_x", 32'(o_Ball_X), 32'(m_x));
        chk("ball_y", 32'(o_Ball_Y), 32'(m_y));
        chk("p1_score", 32'(o_P1_Score), 32'(m_s1));
        chk("p2_score", 32'(o_P2_Score), 32'(m_s2));
        chk("point", 32'(o_Point), 32'(m_point));
    endtask

    // driver: one clock with given strobes and pixel counts
    task automatic cycle(input bit fe, input bit st, input int h, input int v);
        i_Frame_end = fe;
        i_Start     = st;
        i_H_count   = HCW'(h);
        i_V_count   = VCW'(v);
        exp_q.push_back(model_draw(h, v));
        model_edge(fe, st, int'(i_P1_Paddle_Y), int'(i_P2_Paddle_Y));
        @(posedge clk); #1;
        i_Frame_end = 1'b0;
        i_Start     = 1'b0;
        chk("draw", 32'(o_Draw_Ball), 32'(exp_q.pop_front()));
        check_outputs();
    endtask

    // one short frame: frame-end cycle, then probes with junk paddle values
    task automatic frame(input int p1y, input int p2y, input bit st_on_fe, input int start_pct);
        i_P1_Paddle_Y = PYW'(p1y);
        i_P2_Paddle_Y = PYW'(p2y);
        cycle(1'b1, st_on_fe, rand_h(), rand_v());
        i_P1_Paddle_Y = PYW'($urandom_range(0, V_ACTIVE - 1));
        i_P2_Paddle_Y = PYW'($urandom_range(0, V_ACTIVE - 1));
        repeat (2) cycle(1'b0, int'($urandom_range(0, 99)) < start_pct, rand_h(), rand_v());
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(o_State), 32'd0);
        chk({tag, "_x"}, 32'(o_Ball_X), 32'(CX));
        chk({tag, "_y"}, 32'(o_Ball_Y), 32'(CY));
        chk({tag, "_p1"}, 32'(o_P1_Score), 32'd0);
        chk({tag, "_p2"}, 32'(o_P2_Score), 32'd0);
        chk({tag, "_point"}, 32'(o_Point), 32'd0);
        chk({tag, "_draw"}, 32'(o_Draw_Ball), 32'd0);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("rst");
        model_reset();
        i_Reset = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int guard;
        bit in_first_point;
        bit first_done;

        i_Reset = 1'b1; i_Frame_end = 1'b0; i_Start = 1'b0;
        i_H_count = '0; i_V_count = '0; i_P1_Paddle_Y = '0; i_P2_Paddle_Y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("init");
        i_Reset = 1'b0;

        // idle frames keep the ball parked and drawn at centre
        repeat (3) frame(int'($urandom_range(0, 415)), int'($urandom_range(0, 415)), 1'b0, 0);

        // start on a frame-end cycle: play begins, no motion that frame
        frame(200, 200, 1'b1, 0);
        chk("start_state", 32'(o_State), 32'd1);
        chk("start_no_move_x", 32'(o_Ball_X), 32'(CX));
        frame(200, 200, 1'b0, 0);
        chk("first_frame_x", 32'(o_Ball_X), 32'(CX + BALL_SPEED));
        chk("first_frame_y", 32'(o_Ball_Y), 32'(CY + BALL_SPEED));

        // randomized play with occasional start pulses
        for (int f = 0; f < 1500; f++) begin
            int p1, p2;
            p1 = ($urandom_range(0, 9) < 4) ? track(m_y) : int'($urandom_range(0, V_ACTIVE - 1));
            p2 = ($urandom_range(0, 9) < 4) ? track(m_y) : int'($urandom_range(0, V_ACTIVE - 1));
            frame(p1, p2, $urandom_range(0, 19) == 0, 3);
        end

        // P1 defends every rally and P2 never does, until game over
        do_reset();
        cycle(1'b0, 1'b1, rand_h(), rand_v());
        hold = 0; in_first_point = 0; first_done = 0; guard = 0;
        while (m_state != 3 && guard < 3000) begin
            frame(track(m_y), avoid(m_y), 1'b0, 0);
            guard++;
            if (!first_done) begin
                if (o_State == 2'd2) begin
                    in_first_point = 1;
                    hold++;
                    chk("serve_hold_x", 32'(o_Ball_X), 32'(CX));
                    chk("serve_hold_y", 32'(o_Ball_Y), 32'(CY));
                end else if (in_first_point) begin
                    first_done = 1;
                    chk("serve_hold_frames", 32'(hold), 32'(SERVE_FRAMES));
                    chk("serve_state_play", 32'(o_State), 32'd1);
                end
            end
        end
        chk("game_over_state", 32'(o_State), 32'd3);
        chk("game_over_p1", 32'(o_P1_Score), 32'(WIN_SCORE));
        chk("game_over_p2", 32'(o_P2_Score), 32'd0);

        // ball hidden in game over, frame ends change nothing
        for (int dy = 0; dy < BALL_SIZE; dy += 3)
            for (int dx = 0; dx < BALL_SIZE; dx += 3)
                cycle(1'b0, 1'b0, CX + dx, CY + dy);
        frame(100, 100, 1'b0, 0);
        chk("game_over_frozen_p1", 32'(o_P1_Score), 32'(WIN_SCORE));

        // restart from game over
        cycle(1'b0, 1'b1, CX + 1, CY + 1);
        chk("restart_state", 32'(o_State), 32'd1);
        chk("restart_p1", 32'(o_P1_Score), 32'd0);
        chk("restart_x", 32'(o_Ball_X), 32'(CX));

        // rally until the ball passes x=100 leftward, then reset asynchronously
        guard = 0;
        while (!(m_state == 1 && m_x == 100) && guard < 1500) begin
            frame(track(m_y), track(m_y), 1'b0, 2);
            guard++;
        end
        chk("pre_reset_x", 32'(o_Ball_X), 32'd100);
        #3;
        i_Reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk); #1;
        i_Reset = 1'b0;
        repeat (2) frame(200, 200, 1'b0, 0);
        chk("post_reset_idle", 32'(o_State), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
